multicycle_controller: RTL and testbench

Multi-cycle sequencer for the 64-bit RISC-V datapath. It breaks each instruction into FETCH / DECODE / EXECUTE / MEM / WRITEBACK steps and drives the per-step enables for the datapath's existing stages:
- PC and instruction register writes
- register-file write, data-memory read and write
- write-back and ALU-operand mux selects

It waits on a data-memory ready handshake, traps every invalid flag the stages raise into a sticky HALT state with an error code, and counts retired instructions.

---
 rtl/multicycle_controller_pkg.sv | 42 ++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller_opcode_classifier.sv | 22 ++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 tb/tb_multicycle_controller.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, opcodes,
// opcode classes and trap causes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // CL_NONE is the reset value of the latched class; it never reaches EXECUTE
    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_R      = 3'd1,
        CL_I      = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5
    } op_class_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_FETCH   = 3'd1;
    localparam logic [2:0] ERR_OPCODE  = 3'd2;
    localparam logic [2:0] ERR_FUNCT   = 3'd3;
    localparam logic [2:0] ERR_REGADDR = 3'd4;
    localparam logic [2:0] ERR_MEMADDR = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd6;

    function automatic logic uses_imm(input op_class_t c);
        return (c == CL_I) || (c == CL_LOAD) || (c == CL_STORE);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath-facing signal bundle of the sequencer: stage flags and memory
// handshake in, per-step enables and status out.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instruction;
    logic             invAddr;
    logic             invOp;
    logic             invFunc;
    logic             invRegAddr;
    logic             invMemAddr;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic [2:0]       state;
    logic             halted;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  instruction, invAddr, invOp, invFunc, invRegAddr, invMemAddr, mem_ready,
        output ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src, branch, state, halted, err_code, retired
    );

    modport master (
        output instruction, invAddr, invOp, invFunc, invRegAddr, invMemAddr, mem_ready,
        input  ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg,
               alu_src, branch, state, halted, err_code, retired
    );
endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Maps a 7-bit RISC-V opcode to its instruction class; valid=0 for anything
// the sequencer does not implement.
module opcode_classifier
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       valid
);
    always_comb begin
        op_class = CL_NONE;
        valid    = 1'b1;
        case (opcode)
            OPC_R:      op_class = CL_R;
            OPC_I:      op_class = CL_I;
            OPC_LOAD:   op_class = CL_LOAD;
            OPC_STORE:  op_class = CL_STORE;
            OPC_BRANCH: op_class = CL_BRANCH;
            default:    valid    = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with sticky trap
// state and a retired-instruction counter.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    op_class_t         op_q, op_d;
    logic [2:0]        err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q;
    logic              pc_write;
    op_class_t         dec_class;
    logic              dec_valid;
    logic              unused_bits;

    assign unused_bits = ^bus.instruction[31:7];

    opcode_classifier u_cls (
        .opcode   (bus.instruction[6:0]),
        .op_class (dec_class),
        .valid    (dec_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= CL_NONE;
            err_q     <= ERR_NONE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            if (pc_write)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        err_d          = err_q;
        wait_d         = wait_q;
        pc_write       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ir_write = 1'b1;
                if (bus.invAddr) begin
                    state_d = S_HALT;
                    err_d   = ERR_FETCH;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d    = dec_class;
                state_d = S_HALT;
                if (bus.invOp)           err_d = ERR_OPCODE;
                else if (bus.invFunc)    err_d = ERR_FUNCT;
                else if (bus.invRegAddr) err_d = ERR_REGADDR;
                else if (!dec_valid)     err_d = ERR_OPCODE;
                else                     state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                bus.alu_src = uses_imm(op_q);
                case (op_q)
                    CL_R, CL_I: state_d = S_WRITEBACK;
                    CL_LOAD, CL_STORE: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    CL_BRANCH: begin
                        bus.branch = 1'b1;
                        pc_write   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        state_d = S_HALT;
                        err_d   = ERR_OPCODE;
                    end
                endcase
            end
            S_MEM: begin
                bus.alu_src   = uses_imm(op_q);
                bus.mem_read  = (op_q == CL_LOAD);
                bus.mem_write = (op_q == CL_STORE);
                // an address fault wins over a completing access
                if (bus.invMemAddr) begin
                    state_d = S_HALT;
                    err_d   = ERR_MEMADDR;
                end else if (bus.mem_ready) begin
                    if (op_q == CL_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (op_q == CL_LOAD);
                bus.alu_src    = uses_imm(op_q);
                pc_write       = 1'b1;
                state_d        = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.pc_write = pc_write;
    assign bus.state    = state_q;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.err_code = err_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Instruction-level bench: builds the expected per-cycle trace of each
// instruction from its class, memory latency and injected fault.
module tb_multicycle_controller;
    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 15;

    localparam logic [6:0] R_OP  = 7'h33;
    localparam logic [6:0] I_OP  = 7'h13;
    localparam logic [6:0] LD_OP = 7'h03;
    localparam logic [6:0] ST_OP = 7'h23;
    localparam logic [6:0] BR_OP = 7'h63;

    // fault kinds
    localparam int F_NONE = 0, F_ADDR = 1, F_OP = 2, F_FUNC = 3, F_REG = 4;
    localparam int F_MEM = 5, F_RST = 6, F_OPFUNC = 7;

    logic clock, reset;
    multicycle_controller_if #(.CNT_W(CNT_W)) bus();

    multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_ret = 0;
    int          m_err = 0;
    bit          m_halt = 0;

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            R_OP:    return 0;
            I_OP:    return 1;
            LD_OP:   return 2;
            ST_OP:   return 3;
            BR_OP:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] pk(input int st, input int err, input bit ir, input bit pc,
                                       input bit rw, input bit mr, input bit mw, input bit m2r,
                                       input bit alu, input bit br);
        return {17'b0, 3'(st), st == 7, 3'(err), ir, pc, rw, mr, mw, m2r, alu, br};
    endfunction

    function automatic logic [31:0] obs();
        return {17'b0, bus.state, bus.halted, bus.err_code, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.branch};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic drv(input logic [31:0] ins, input bit ia, input bit io, input bit ifn,
                       input bit ir, input bit im, input bit rdy);
        bus.instruction = ins;
        bus.invAddr     = ia;
        bus.invOp       = io;
        bus.invFunc     = ifn;
        bus.invRegAddr  = ir;
        bus.invMemAddr  = im;
        bus.mem_ready   = rdy;
    endtask

    // inputs already driven; check before the edge, then take the edge
    task automatic step(input string tag, input logic [31:0] e);
        #1;
        check(tag, obs(), e);
        check({tag, "_retired"}, bus.retired, m_ret);
        @(posedge clock);
        #1;
    endtask

    task automatic trap(input int err);
        m_err  = err;
        m_halt = 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_ret = 0; m_err = 0; m_halt = 0;
        check("reset_outputs", obs(), pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("reset_retired", bus.retired, m_ret);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int waits, input int fault, input int fault_at);
        int c;
        bit imm, rdy, im, pcw;
        logic [31:0] r;
        c   = cls_of(ins[6:0]);
        imm = (c == 1) || (c == 2) || (c == 3);
        drv(ins, fault == F_ADDR, 0, 0, 0, 0, 0);
        step("fetch", pk(0, m_err, 1, 0, 0, 0, 0, 0, 0, 0));
        if (fault == F_ADDR) begin trap(1); return; end
        drv(ins, 0, fault == F_OP || fault == F_OPFUNC, fault == F_FUNC || fault == F_OPFUNC, fault == F_REG, 0, 0);
        step("decode", pk(1, m_err, 0, 0, 0, 0, 0, 0, 0, 0));
        if (fault == F_OP || fault == F_OPFUNC) begin trap(2); return; end
        if (fault == F_FUNC) begin trap(3); return; end
        if (fault == F_REG)  begin trap(4); return; end
        if (c < 0)           begin trap(2); return; end
        drv(ins, 0, 0, 0, 0, 0, 0);
        step("execute", pk(2, m_err, 0, c == 4, 0, 0, 0, 0, imm, c == 4));
        if (c == 4) begin m_ret++; return; end
        if (c == 2 || c == 3) begin
            for (int k = 0; ; k++) begin
                rdy = (k == waits);
                im  = (fault == F_MEM) && (k == fault_at);
                r   = $urandom();
                if (fault == F_RST && k == fault_at) begin
                    drv(ins, r[0], r[1], r[2], r[3], 0, 0);
                    #1;
                    check("mem_before_reset", obs(), pk(3, m_err, 0, 0, 0, c == 2, c == 3, 0, 1, 0));
                    #1;
                    apply_reset();
                    return;
                end
                // unrelated stage flags are noise outside their sampling state
                drv(ins, r[0], r[1], r[2], r[3], im, rdy);
                pcw = (c == 3) && rdy && !im;
                step("mem", pk(3, m_err, 0, pcw, 0, c == 2, c == 3, 0, 1, 0));
                if (im) begin trap(5); return; end
                if (rdy) begin
                    if (c == 3) begin m_ret++; return; end
                    break;
                end
                if (k == MEM_TIMEOUT - 1) begin trap(6); return; end
            end
        end
        drv(ins, 0, 0, 0, 0, 0, 0);
        step("writeback", pk(4, m_err, 0, 1, 1, 0, 0, c == 2, imm, 0));
        m_ret++;
    endtask

    task automatic halt_hold(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            drv(r, r[7], r[8], r[9], r[10], r[11], r[12]);
            step("halt", pk(7, m_err, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        logic [6:0]  ops [7];
        logic [31:0] r;
        int          sel, waits, fault, fat;
        ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, 7'h7F, 7'h37};
        drv(0, 0, 0, 0, 0, 0, 0);
        apply_reset();

        do_instr(32'h002081B3, 0, F_NONE, 0);
        do_instr(32'h0000B183, 2, F_NONE, 0);
        do_instr(32'h00C00093, 0, F_NONE, 0);
        do_instr(32'h0020A023, 15, F_NONE, 0);
        halt_hold(3);
        apply_reset();

        do_instr(32'h0000007F, 0, F_OPFUNC, 0);
        halt_hold(10);
        apply_reset();

        do_instr(32'h00000063, 0, F_NONE, 0);
        do_instr(32'h00000063, 0, F_NONE, 0);
        do_instr(32'h00000063, 0, F_NONE, 0);
        do_instr(32'h0000B183, 3, F_RST, 1);

        do_instr(32'h002081B3, 0, F_ADDR, 0);
        halt_hold(2);
        apply_reset();
        do_instr(32'h002081B3, 0, F_REG, 0);
        halt_hold(2);
        apply_reset();
        do_instr(32'h0000B183, 3, F_MEM, 3);
        halt_hold(2);
        apply_reset();
        do_instr(32'h00000037, 0, F_NONE, 0);
        halt_hold(2);
        apply_reset();

        for (int i = 0; i < 80; i++) begin
            r     = $urandom();
            sel   = $urandom_range(0, 6);
            waits = ($urandom_range(0, 9) == 0) ? $urandom_range(MEM_TIMEOUT - 1, MEM_TIMEOUT + 2)
                                                : $urandom_range(0, 3);
            fault = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : F_NONE;
            fat   = $urandom_range(0, waits);
            do_instr({r[31:7], ops[sel]}, waits, fault, fat);
            if (m_halt) begin
                halt_hold(2);
                apply_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
